// File: rtl/block_data_memory.sv
// -----------------------------------------------------------------------------
// block_data_memory
//
// Word-organised backing store that answers block requests from a data cache.
// Each accepted request is served after a fixed latency: the request is latched
// in IDLE, the memory spends LATENCY cycles in BUSY, the access happens on the
// last BUSY edge, and a single DONE cycle drops busywait so the initiator can
// see that the access has finished.
//
// Parameters
//   ADDR_W   block address width (depth = 2**ADDR_W blocks)
//   DATA_W   block width in bits
//   LATENCY  cycles spent in BUSY per access (>= 1)
//
// Ports
//   clock_i      clock; all state changes happen on the rising edge
//   reset_ni     asynchronous active-low reset; clears FSM, readdata and memory
//   read_i       block read request, held by the initiator until busywait drops
//   write_i      block write request; it takes priority when read_i is also high
//   address_i    block address
//   writedata_i  block to write
//   readdata_o   registered read result; only a completed read updates it
//   busywait_o   high while a request is pending (IDLE) or in service (BUSY)
// -----------------------------------------------------------------------------
module block_data_memory #(
    parameter int ADDR_W  = 6,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 5
) (
    input  logic              clock_i,
    input  logic              reset_ni,
    input  logic              read_i,
    input  logic              write_i,
    input  logic [ADDR_W-1:0] address_i,
    input  logic [DATA_W-1:0] writedata_i,
    output logic [DATA_W-1:0] readdata_o,
    output logic              busywait_o
);

    localparam int DEPTH = 2 ** ADDR_W;
    // The counter only has to hold LATENCY-1 down to 0.
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                is_write_q, is_write_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   readdata_q, readdata_d;
    logic                mem_we;

    logic [DATA_W-1:0]   mem_q [DEPTH];

    // Next-state and output logic.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        is_write_d = is_write_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        readdata_d = readdata_q;
        mem_we     = 1'b0;
        busywait_o = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // busywait rises in the same cycle as the request so the
                // initiator never sees a stale low at its next edge.
                if (read_i || write_i) begin
                    busywait_o = 1'b1;
                    state_d    = ST_BUSY;
                    count_d    = CNT_LOAD;
                    is_write_d = write_i;   // write wins a read/write collision
                    addr_d     = address_i;
                    wdata_d    = writedata_i;
                end
            end
            ST_BUSY: begin
                busywait_o = 1'b1;
                if (count_q == '0) begin
                    // Last BUSY edge: perform the latched access.
                    state_d = ST_DONE;
                    if (is_write_q) begin
                        mem_we = 1'b1;
                    end else begin
                        readdata_d = mem_q[addr_q];
                    end
                end else begin
                    count_d = count_q - CNT_W'(1);
                end
            end
            ST_DONE: begin
                // Single cycle with busywait low; requests are not sampled here.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and request-latch registers.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            is_write_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            readdata_q <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            is_write_q <= is_write_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            readdata_q <= readdata_d;
        end
    end

    // Storage array. Reset clears every block, and a reset during BUSY
    // discards the pending write because mem_we never fires.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[addr_q] <= wdata_q;
        end
    end

    assign readdata_o = readdata_q;

endmodule

// File: tb/tb_block_data_memory.sv
// -----------------------------------------------------------------------------
// tb_block_data_memory
//
// Drives two instances of block_data_memory (LATENCY=5 and LATENCY=1) from a
// shared request bus; `sel` routes the request to one of them. A behavioural
// model (array of blocks plus last read value per instance) provides the
// expected readdata, and the expected handshake length is computed from the
// latency.
// -----------------------------------------------------------------------------
module tb_block_data_memory;

    localparam int AW = 6;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          sel;
    logic          req_r, req_w;
    logic [AW-1:0] req_a;
    logic [DW-1:0] req_d;

    logic          r5, w5, r1, w1;
    logic          bw5, bw1, bw;
    logic [DW-1:0] rd5, rd1, rd;

    always #5 clk = ~clk;

    assign r5 = req_r & ~sel;
    assign w5 = req_w & ~sel;
    assign r1 = req_r & sel;
    assign w1 = req_w & sel;
    assign bw = sel ? bw1 : bw5;
    assign rd = sel ? rd1 : rd5;

    block_data_memory #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(5)) dut5 (
        .clock_i     (clk),
        .reset_ni    (rst_n),
        .read_i      (r5),
        .write_i     (w5),
        .address_i   (req_a),
        .writedata_i (req_d),
        .readdata_o  (rd5),
        .busywait_o  (bw5)
    );

    block_data_memory #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(1)) dut1 (
        .clock_i     (clk),
        .reset_ni    (rst_n),
        .read_i      (r1),
        .write_i     (w1),
        .address_i   (req_a),
        .writedata_i (req_d),
        .readdata_o  (rd1),
        .busywait_o  (bw1)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: [0] mirrors LATENCY=5, [1] mirrors LATENCY=1.
    logic [DW-1:0] mmem [2][64];
    logic [DW-1:0] mrd  [2];

    typedef struct {
        bit          r;
        bit          w;
        logic [5:0]  a;
        logic [31:0] d;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t tbl [8];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            mrd[s] = '0;
            for (int i = 0; i < 64; i++) mmem[s][i] = '0;
        end
    endtask

    // One complete request/handshake; churn scrambles the inputs during BUSY.
    task automatic access(input bit s, input bit r, input bit w, input logic [5:0] a,
                          input logic [31:0] d, input bit churn, input string tag);
        int          lat;
        int          cyc;
        logic [31:0] exp;
        lat = s ? 1 : 5;
        exp = w ? mrd[s] : mmem[s][a];
        @(negedge clk);
        sel = s; req_r = r; req_w = w; req_a = a; req_d = d;
        #1 check({tag, " busy_on_req"}, DW'(bw), DW'(1));
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
            if (churn && cyc == 1) begin
                req_a = '0; req_d = ~d; req_r = 1'b0; req_w = 1'b0;
            end
        end while (bw && cyc < 40);
        check({tag, " cycles"}, DW'(cyc), DW'(lat + 1));
        check({tag, " readdata"}, rd, exp);
        if (w) mmem[s][a] = d;
        else   mrd[s] = mmem[s][a];
        @(negedge clk);
        req_r = 1'b0; req_w = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        int op;
        logic [5:0]  a;
        logic [31:0] d;

        tbl[0] = '{r: 1'b0, w: 1'b1, a: 6'h2A, d: 32'hDEADBEEF, exp_rd: 32'h00000000};
        tbl[1] = '{r: 1'b1, w: 1'b0, a: 6'h2A, d: 32'h0,        exp_rd: 32'hDEADBEEF};
        tbl[2] = '{r: 1'b0, w: 1'b1, a: 6'h05, d: 32'h11223344, exp_rd: 32'hDEADBEEF};
        tbl[3] = '{r: 1'b1, w: 1'b0, a: 6'h05, d: 32'h0,        exp_rd: 32'h11223344};
        tbl[4] = '{r: 1'b1, w: 1'b1, a: 6'h3F, d: 32'hCAFEF00D, exp_rd: 32'h11223344};
        tbl[5] = '{r: 1'b1, w: 1'b0, a: 6'h3F, d: 32'h0,        exp_rd: 32'hCAFEF00D};
        tbl[6] = '{r: 1'b1, w: 1'b0, a: 6'h00, d: 32'h0,        exp_rd: 32'h00000000};
        tbl[7] = '{r: 1'b1, w: 1'b0, a: 6'h2A, d: 32'h0,        exp_rd: 32'hDEADBEEF};

        rst_n = 1'b0; sel = 1'b0; req_r = 1'b0; req_w = 1'b0; req_a = '0; req_d = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check("reset rd5", rd5, '0);
        check("reset rd1", rd1, '0);
        check("reset bw5", DW'(bw5), '0);
        check("reset bw1", DW'(bw1), '0);
        rst_n = 1'b1;

        // Directed table on the LATENCY=5 instance.
        for (int i = 0; i < 8; i++) begin
            access(1'b0, tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d, 1'b0, $sformatf("tbl%0d", i));
            check($sformatf("tbl%0d table_rd", i), rd5, tbl[i].exp_rd);
        end

        // Input churn: latched request completes, mem[0] untouched.
        access(1'b0, 1'b1, 1'b0, 6'h2A, 32'h0, 1'b1, "churn_rd");
        access(1'b0, 1'b0, 1'b1, 6'h2A, 32'hA5A50001, 1'b1, "churn_wr");
        access(1'b0, 1'b1, 1'b0, 6'h00, 32'h0, 1'b0, "churn_mem0");
        check("churn mem0 value", rd5, 32'h0);
        access(1'b0, 1'b1, 1'b0, 6'h2A, 32'h0, 1'b0, "churn_mem2a");
        check("churn mem2a value", rd5, 32'hA5A50001);

        // Write-back then fill with the read raised right after DONE.
        @(negedge clk);
        sel = 1'b0; req_w = 1'b1; req_r = 1'b0; req_a = 6'h05; req_d = 32'h11223344;
        cyc = 0;
        do begin @(posedge clk); #1; cyc++; end while (bw5 && cyc < 40);
        check("b2b write cycles", DW'(cyc), DW'(6));
        mmem[0][5] = 32'h11223344;
        req_w = 1'b0; req_r = 1'b1;
        #1 check("b2b done ignores req", DW'(bw5), '0);
        cyc = 0;
        do begin
            @(posedge clk); #1; cyc++;
            if (cyc == 1) check("b2b idle busy", DW'(bw5), DW'(1));
        end while (bw5 && cyc < 40);
        check("b2b read cycles", DW'(cyc), DW'(7));
        check("b2b readdata", rd5, 32'h11223344);
        mrd[0] = 32'h11223344;
        @(negedge clk); req_r = 1'b0;
        @(posedge clk); #1;

        // Random traffic on both instances against the model.
        for (int i = 0; i < 60; i++) begin
            op = int'($urandom_range(0, 2));
            a  = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(0, 7)) : 6'($urandom);
            d  = $urandom;
            access((i >= 40), (op != 1), (op != 0), a, d, 1'b0, $sformatf("rnd%0d", i));
        end

        // LATENCY=1 directed pair with churn.
        access(1'b1, 1'b0, 1'b1, 6'h2A, 32'h0BADF00D, 1'b1, "l1_wr");
        access(1'b1, 1'b1, 1'b0, 6'h2A, 32'h0, 1'b0, "l1_rd");
        check("l1 value", rd1, 32'h0BADF00D);

        // Reset mid-run clears readdata and memory.
        @(negedge clk);
        rst_n = 1'b0; req_r = 1'b0; req_w = 1'b0;
        #1;
        check("midrun rst rd5", rd5, '0);
        check("midrun rst rd1", rd1, '0);
        check("midrun rst bw5", DW'(bw5), '0);
        model_reset();
        @(negedge clk); rst_n = 1'b1;
        access(1'b0, 1'b1, 1'b0, 6'h2A, 32'h0, 1'b0, "post_rst5");
        access(1'b1, 1'b1, 1'b0, 6'h05, 32'h0, 1'b0, "post_rst1");

        // Reset asserted during BUSY of a write to 0x10 aborts the write.
        access(1'b0, 1'b1, 1'b0, 6'h05, 32'h0, 1'b0, "pre_abort"); // readdata stays 0
        @(negedge clk);
        sel = 1'b0; req_w = 1'b1; req_a = 6'h10; req_d = 32'hFFFF0010;
        @(posedge clk); @(posedge clk);
        #1 check("abort busy", DW'(bw5), DW'(1));
        #2 rst_n = 1'b0; req_w = 1'b0;
        #1;
        check("abort bw", DW'(bw5), '0);
        check("abort rd", rd5, '0);
        model_reset();
        @(negedge clk); rst_n = 1'b1;
        access(1'b0, 1'b1, 1'b0, 6'h10, 32'h0, 1'b0, "abort_mem10");
        check("abort mem10 value", rd5, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
